// File: rtl/bp_me_wormhole_packet_serializer.sv
// bp_me_wormhole_packet_serializer
//
// Takes one whole packet from the LCE command packet encoder and sends it
// out as max_num_flit_p-wide wormhole flits, lowest flit first. The head
// flit carries the coordinate and length fields exactly as received.
//
// Ports:
//   clk_i      clock
//   reset_i    asynchronous active-high reset
//   packet_i   packet {payload, length, y_cord, x_cord} from the encoder
//   v_i        packet_i valid
//   ready_o    serializer can accept a packet (low while reset_i is high)
//   data_o     current flit (driven only from registered state)
//   v_o        data_o valid
//   ready_i    link accepts the flit
//   len_err_o  sticky: some packet's length field exceeded max_num_flit_p-1
//
// Build option:
//   BP_ME_SERIALIZER_BACK_TO_BACK_EN - when defined, a new packet can be
//   accepted on the last-flit handshake cycle, so consecutive packets go out
//   with no bubble. ready_o then depends combinationally on ready_i.
//   When undefined, packets are accepted only in IDLE and one empty cycle
//   separates consecutive packets.

module bp_me_wormhole_packet_serializer #(
    parameter int max_num_flit_p     = 4,
    parameter int flit_width_p       = 16,
    parameter int x_cord_width_p     = 4,
    parameter int y_cord_width_p     = 4,
    parameter int max_packet_width_p = 64,
    localparam int len_width_lp      = (max_num_flit_p == 1) ? 1 : $clog2(max_num_flit_p)
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic [max_packet_width_p-1:0] packet_i,
    input  logic                          v_i,
    output logic                          ready_o,
    output logic [flit_width_p-1:0]       data_o,
    output logic                          v_o,
    input  logic                          ready_i,
    output logic                          len_err_o
);

    localparam int padded_width_lp = max_num_flit_p * flit_width_p;
    localparam int len_lsb_lp      = x_cord_width_p + y_cord_width_p;
    localparam logic [len_width_lp-1:0] max_len_lp = len_width_lp'(max_num_flit_p - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    state_e                     state_reg, state_next;
    logic [padded_width_lp-1:0] packet_reg, packet_next, packet_padded;
    logic [len_width_lp-1:0]    cnt_reg, cnt_next;
    logic [len_width_lp-1:0]    len_reg, len_next;
    logic [len_width_lp-1:0]    len_field;
    logic                       len_err_reg, len_err_next;
    logic                       ready_int;
    logic                       accept;

    assign len_field = packet_i[len_lsb_lp +: len_width_lp];

    always_comb begin
        packet_padded = '0;
        packet_padded[max_packet_width_p-1:0] = packet_i;
    end

    // Split the registered packet into flits; data_o is a mux over these,
    // so nothing on packet_i can reach data_o in the same cycle.
    logic [flit_width_p-1:0] flits [max_num_flit_p];

    generate
        for (genvar gi = 0; gi < max_num_flit_p; gi++) begin : g_flit
            assign flits[gi] = packet_reg[gi*flit_width_p +: flit_width_p];
        end
    endgenerate

    assign data_o    = flits[cnt_reg];
    assign len_err_o = len_err_reg;

    always_comb begin
        state_next   = state_reg;
        packet_next  = packet_reg;
        cnt_next     = cnt_reg;
        len_next     = len_reg;
        len_err_next = len_err_reg;
        ready_int    = 1'b0;
        v_o          = 1'b0;

        case (state_reg)
            IDLE: begin
                ready_int = 1'b1;
            end
            SEND: begin
                v_o = 1'b1;
                if (ready_i) begin
                    if (cnt_reg == len_reg) begin
                        state_next = IDLE;
`ifdef BP_ME_SERIALIZER_BACK_TO_BACK_EN
                        ready_int = 1'b1;
`endif
                    end else begin
                        cnt_next = cnt_reg + len_width_lp'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // No acceptance is advertised while reset is held, even though the
        // state register already reads IDLE.
        ready_o = ready_int & ~reset_i;
        accept  = v_i & ready_o;

        // A capture overrides the return to IDLE above, which is what gives
        // back-to-back packets their bubble-free hand-off.
        if (accept) begin
            packet_next = packet_padded;
            cnt_next    = '0;
            state_next  = SEND;
            if (len_field > max_len_lp) begin
                len_next     = max_len_lp;
                len_err_next = 1'b1;
            end else begin
                len_next = len_field;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_reg   <= IDLE;
            packet_reg  <= '0;
            cnt_reg     <= '0;
            len_reg     <= '0;
            len_err_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            packet_reg  <= packet_next;
            cnt_reg     <= cnt_next;
            len_reg     <= len_next;
            len_err_reg <= len_err_next;
        end
    end

endmodule

// File: tb/tb_bp_me_wormhole_packet_serializer.sv
module tb_bp_me_wormhole_packet_serializer;

    localparam int MAXF = 4;
    localparam int FW   = 16;

    logic        clk;
    logic        reset_i;
    logic [63:0] packet_i;
    logic        v_i;
    logic        ready_o;
    logic [15:0] data_o;
    logic        v_o;
    logic        ready_i;
    logic        len_err_o;

    // Second instance with only 3 flits so the length field can overflow.
    logic        rst3;
    logic [47:0] pkt3;
    logic        v3;
    logic        rdy3;
    logic [15:0] d3;
    logic        vo3;
    logic        ri3;
    logic        err3;

    bp_me_wormhole_packet_serializer #(
        .max_num_flit_p(MAXF), .flit_width_p(FW), .x_cord_width_p(4),
        .y_cord_width_p(4), .max_packet_width_p(64)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .packet_i(packet_i), .v_i(v_i),
        .ready_o(ready_o), .data_o(data_o), .v_o(v_o), .ready_i(ready_i),
        .len_err_o(len_err_o)
    );

    bp_me_wormhole_packet_serializer #(
        .max_num_flit_p(3), .flit_width_p(16), .x_cord_width_p(4),
        .y_cord_width_p(4), .max_packet_width_p(48)
    ) dut3 (
        .clk_i(clk), .reset_i(rst3), .packet_i(pkt3), .v_i(v3),
        .ready_o(rdy3), .data_o(d3), .v_o(vo3), .ready_i(ri3),
        .len_err_o(err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    // Reference model: the flits still owed to the link, in order.
    logic [15:0] exp_q[$];
    bit          model_err;

    // Observations from the most recent cycle.
    bit          last_fired;
    bit          last_accepted;
    logic [15:0] last_data;
    bit          last_v;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // A packet owes min(len, MAXF-1)+1 flits, taken low bits first.
    task automatic push_packet(input logic [63:0] pkt);
        int len;
        len = int'(pkt[9:8]);
        if (len > MAXF - 1) begin
            len = MAXF - 1;
            model_err = 1'b1;
        end
        for (int k = 0; k <= len; k++) exp_q.push_back(pkt[k*FW +: FW]);
    endtask

    // One clock: drive at posedge+1, check at negedge, update model after posedge.
    task automatic cycle(input logic v, input logic [63:0] pkt, input logic rdy);
        bit er, ev;
        v_i = v; packet_i = pkt; ready_i = rdy;
        @(negedge clk);
        ev = (exp_q.size() != 0);
`ifdef BP_ME_SERIALIZER_BACK_TO_BACK_EN
        er = (exp_q.size() == 0) || (exp_q.size() == 1 && rdy);
`else
        er = (exp_q.size() == 0);
`endif
        chk("ready_o", 64'(ready_o), 64'(er));
        chk("v_o", 64'(v_o), 64'(ev));
        if (ev) chk("data_o", 64'(data_o), 64'(exp_q[0]));
        chk("len_err_o", 64'(len_err_o), 64'(model_err));
        last_v        = v_o;
        last_data     = data_o;
        last_fired    = v_o & rdy;
        last_accepted = v & er;
        @(posedge clk);
        #1;
        if (ev && rdy) void'(exp_q.pop_front());
        if (last_accepted) push_packet(pkt);
    endtask

    task automatic run_packet(input logic [63:0] pkt, output int n,
                              output logic [15:0] head, output logic [15:0] tail);
        int guard;
        n = 0; head = '0; tail = '0; guard = 0;
        do begin
            cycle(1'b1, pkt, 1'b1);
            guard++;
        end while (!last_accepted && guard < 20);
        if (!last_accepted) chk("accept_timeout", 64'(0), 64'(1));
        guard = 0;
        while (exp_q.size() != 0 && guard < 40) begin
            cycle(1'b0, pkt, 1'b1);
            if (last_fired) begin
                if (n == 0) head = last_data;
                tail = last_data;
                n++;
            end
            guard++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'(0));
    endtask

    typedef struct {
        logic [63:0] pkt;
        int          nflits;
        logic [15:0] head;
        logic [15:0] tail;
    } vec_t;

    vec_t tbl[4];

    localparam logic [63:0] FULL_PKT = 64'hDEAD_BEEF_CAFE_0300;

    initial begin
        int          n;
        int          guard;
        logic [15:0] h, t;
        logic [16:0] obs[$];
        logic [16:0] exp_obs[$];
        logic [15:0] exp3[3];

        tbl[0] = '{64'h0000_0000_0000_0023, 1, 16'h0023, 16'h0023};
        tbl[1] = '{FULL_PKT,                4, 16'h0300, 16'hDEAD};
        tbl[2] = '{64'h0000_0000_1111_0100, 2, 16'h0100, 16'h1111};
        tbl[3] = '{64'h0000_0000_0000_0011, 1, 16'h0011, 16'h0011};

        model_err = 1'b0;
        reset_i = 1'b1; rst3 = 1'b1;
        v_i = 1'b0; packet_i = '0; ready_i = 1'b0;
        v3 = 1'b0; pkt3 = '0; ri3 = 1'b0;

        #2;
        chk("rst_ready_o", 64'(ready_o), 64'(0));
        chk("rst_v_o", 64'(v_o), 64'(0));
        chk("rst_data_o", 64'(data_o), 64'(0));
        chk("rst_len_err_o", 64'(len_err_o), 64'(0));
        @(posedge clk); @(posedge clk); #1;
        reset_i = 1'b0; rst3 = 1'b0;

        // Table: each packet alone, ready_i held high.
        for (int i = 0; i < 4; i++) begin
            run_packet(tbl[i].pkt, n, h, t);
            chk($sformatf("tbl%0d_nflits", i), 64'(n), 64'(tbl[i].nflits));
            chk($sformatf("tbl%0d_head", i), 64'(h), 64'(tbl[i].head));
            chk($sformatf("tbl%0d_tail", i), 64'(t), 64'(tbl[i].tail));
        end

        // Backpressure while 0xCAFE is presented.
        guard = 0;
        do begin cycle(1'b1, FULL_PKT, 1'b1); guard++; end while (!last_accepted && guard < 20);
        cycle(1'b0, FULL_PKT, 1'b1);
        chk("bp_head", 64'(last_data), 64'(16'h0300));
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, FULL_PKT, 1'b0);
            chk("bp_hold_data", 64'(last_data), 64'(16'hCAFE));
            chk("bp_hold_v", 64'(last_v), 64'(1));
        end
        cycle(1'b0, FULL_PKT, 1'b1);
        chk("bp_cafe", 64'(last_data), 64'(16'hCAFE));
        cycle(1'b0, FULL_PKT, 1'b1);
        chk("bp_beef", 64'(last_data), 64'(16'hBEEF));
        cycle(1'b0, FULL_PKT, 1'b1);
        chk("bp_dead", 64'(last_data), 64'(16'hDEAD));
        cycle(1'b0, FULL_PKT, 1'b1);

        // Back-to-back: A accepted, then B offered continuously.
        guard = 0;
        do begin cycle(1'b1, 64'h0000_0000_1111_0100, 1'b1); guard++; end
        while (!last_accepted && guard < 20);
        begin
            bit b_done;
            b_done = 1'b0;
            for (int i = 0; i < 6; i++) begin
                cycle(!b_done, 64'h0000_0000_2222_0100, 1'b1);
                if (last_accepted) b_done = 1'b1;
                obs.push_back({last_v, last_v ? last_data : 16'h0000});
            end
        end
        exp_obs = '{17'h1_0100, 17'h1_1111,
`ifndef BP_ME_SERIALIZER_BACK_TO_BACK_EN
                    17'h0_0000,
`endif
                    17'h1_0100, 17'h1_2222};
        for (int i = 0; i < exp_obs.size(); i++)
            chk($sformatf("b2b_seq%0d", i), 64'(obs[i]), 64'(exp_obs[i]));

        // Reset in the middle of a packet.
        guard = 0;
        do begin cycle(1'b1, FULL_PKT, 1'b1); guard++; end while (!last_accepted && guard < 20);
        cycle(1'b0, FULL_PKT, 1'b1);
        cycle(1'b0, FULL_PKT, 1'b1);
        chk("mid_cafe", 64'(last_data), 64'(16'hCAFE));
        #2 reset_i = 1'b1;
        #1;
        chk("mid_rst_v_o", 64'(v_o), 64'(0));
        chk("mid_rst_ready_o", 64'(ready_o), 64'(0));
        exp_q.delete();
        @(posedge clk); #1;
        reset_i = 1'b0;
        run_packet(64'h0000_0000_0000_0011, n, h, t);
        chk("post_rst_nflits", 64'(n), 64'(1));
        chk("post_rst_head", 64'(h), 64'(16'h0011));

        // Randomized traffic against the flit-queue model.
        for (int i = 0; i < 400; i++)
            cycle(1'($urandom_range(0, 1)), {$urandom, $urandom}, $urandom_range(0, 3) != 0);
        guard = 0;
        while (exp_q.size() != 0 && guard < 40) begin
            cycle(1'b0, '0, 1'b1);
            guard++;
        end
        cycle(1'b0, '0, 1'b1);

        // Length overflow on the 3-flit instance.
        exp3 = '{16'h0300, 16'h2222, 16'h3333};
        v3 = 1'b1; pkt3 = 48'h3333_2222_0300; ri3 = 1'b1;
        @(negedge clk);
        chk("ovf_ready", 64'(rdy3), 64'(1));
        chk("ovf_err_before", 64'(err3), 64'(0));
        @(posedge clk); #1;
        v3 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("ovf_v%0d", k), 64'(vo3), 64'(1));
            chk($sformatf("ovf_flit%0d", k), 64'(d3), 64'(exp3[k]));
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("ovf_v_after", 64'(vo3), 64'(0));
        chk("ovf_err_set", 64'(err3), 64'(1));
        @(posedge clk); #1;
        v3 = 1'b1; pkt3 = 48'h0000_0000_0011;
        @(posedge clk); #1;
        v3 = 1'b0;
        @(negedge clk);
        chk("ovf_next_flit", 64'(d3), 64'(16'h0011));
        chk("ovf_next_v", 64'(vo3), 64'(1));
        @(posedge clk); @(negedge clk);
        chk("ovf_next_done", 64'(vo3), 64'(0));
        chk("ovf_err_sticky", 64'(err3), 64'(1));
        @(posedge clk); #1;
        rst3 = 1'b1;
        #1;
        chk("ovf_err_clear", 64'(err3), 64'(0));
        @(posedge clk); #1;
        rst3 = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

// File: doc/bp_me_wormhole_packet_serializer.md
Name: bp_me_wormhole_packet_serializer

Overview:
- Sits directly downstream of the LCE command network packet encoder; consumes its packet {payload, length, y_cord, x_cord}.
- Registers one whole packet and emits it as a sequence of fixed-width wormhole flits, low bits first, into the router link.
- Head flit carries the coordinates and length fields unchanged.
- Valid/ready on both sides.

Parameters:
- max_num_flit_p, 4, maximum flits per packet (head included).
- flit_width_p, 16, flit width in bits.
- x_cord_width_p, 4, x coordinate field width.
- y_cord_width_p, 4, y coordinate field width.
- len_width_lp (localparam), `BSG_SAFE_CLOG2(max_num_flit_p), length field width.
- max_packet_width_p, 64, input packet width; must be <= max_num_flit_p*flit_width_p.

Ports:
- clk_i  input  1  clock.
- reset_i  input  1  asynchronous, active-high reset.
- packet_i  input  max_packet_width_p  packet from encoder; bits [x+y-1:0] are coords, [x+y+len_width_lp-1:x+y] are length.
- v_i  input  1  packet_i valid.
- ready_o  output  1  serializer can accept a packet.
- data_o  output  flit_width_p  current flit.
- v_o  output  1  data_o valid.
- ready_i  input  1  link accepts flit.
- len_err_o  output  1  sticky flag: a packet's length field exceeded max_num_flit_p-1.

Behaviour:
- One clock, clk_i. reset_i is asynchronous and active-high.
- Reset values:
  - state=IDLE, v_o=0, data_o=0, len_err_o=0, flit counter=0.
  - ready_o=0 while reset_i is high.
- States:
  - IDLE: ready_o=1, v_o=0.
    - On v_i&ready_o: register packet_i, zero-padded to max_num_flit_p*flit_width_p.
    - Capture len = packet_i length field. If len > max_num_flit_p-1, saturate len to max_num_flit_p-1 and set len_err_o; len_err_o clears only on reset.
    - Clear counter; go to SEND.
  - SEND: v_o=1, data_o = packet_r[cnt*flit_width_p +: flit_width_p].
    - On v_o&ready_i: if cnt==len go to IDLE, else cnt+1.
- Latency: packet accepted at edge t, head flit valid in cycle t+1.
- Flit count per packet: exactly len+1.
- data_o is registered/mux of registered state only, with no combinational path from packet_i. It stays stable while v_o&!ready_i.
- v_i with ready_o=0: ignored, not captured; upstream holds per valid/ready.
- ready_i is don't-care when v_o=0.
- Reset asserted mid-packet:
  - v_o drops asynchronously; the remaining flits are discarded.
  - After release, the next accepted packet starts at flit 0.
- The length field is passed through untouched in the head flit even when saturated.

Optional Feature:
- Macro BP_ME_SERIALIZER_BACK_TO_BACK_EN.
- Defined:
  - ready_o = IDLE | (SEND & cnt==len & ready_i). ready_o is combinationally dependent on ready_i.
  - A packet accepted on the last-flit handshake cycle goes straight to SEND with a new head flit the next cycle, with no bubble.
  - A full throughput of one flit per cycle is sustained.
- Undefined:
  - ready_o = IDLE only.
  - One idle cycle (v_o=0) separates consecutive packets.

Test Plan (defaults: flit 16, 4 flits, x=4, y=4, len 2 bits):
- Single-flit: packet 0x0000_0000_0000_0023 (len=0), ready_i=1 → one flit 0x0023 at t+1, then v_o=0. ready_o returns to 1 the cycle after the flit handshake.
- Full packet: packet 0xDEAD_BEEF_CAFE_0300 (len=3), ready_i=1 → flits 0x0300, 0xCAFE, 0xBEEF, 0xDEAD in 4 consecutive cycles; ready_o=0 throughout.
- Backpressure: same packet, ready_i=0 for 3 cycles while 0xCAFE is presented → data_o holds 0xCAFE and v_o=1 for those 3 cycles. No flit is lost or duplicated; 0xBEEF follows.
- Back-to-back: 0x0000_0000_1111_0100 (len=1) then 0x0000_0000_2222_0100 with v_i held, ready_i=1.
  - Macro defined: flits 0x0100, 0x1111, 0x0100, 0x2222 with no gap.
  - Macro undefined: one v_o=0 cycle after 0x1111.
- Reset mid-packet: assert reset_i after flits 0x0300 and 0xCAFE → v_o=0 immediately. After release, packet 0x0000_0000_0000_0011 yields a single flit 0x0011.
- Length overflow with max_num_flit_p=3: packet with len=3 → exactly 3 flits emitted, len_err_o=1 and stays 1 until reset.
